// File: rtl/cv32e40p_csr_trace_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_csr_trace_pkg
// Shared definitions for the CSR write trace buffer:
//   - CNT_W_DEFAULT : default width of cycle counter, timestamp and drop count
//   - ST_RUN/ST_DRAIN/ST_DONE : capture state machine encodings
//   - trace_entry_t : layout of one buffered entry at the default counter width
// Optional feature macro: CV32E40P_CSR_TRACE_TS_EN (timestamp per entry).
// ---------------------------------------------------------------------------
package cv32e40p_csr_trace_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef logic [1:0] trace_state_t;

    localparam trace_state_t ST_RUN   = 2'd0;
    localparam trace_state_t ST_DRAIN = 2'd1;
    localparam trace_state_t ST_DONE  = 2'd2;

    typedef struct packed {
        logic [31:0]              wdata;
        logic [CNT_W_DEFAULT-1:0] ts;
    } trace_entry_t;

endpackage

// File: rtl/cv32e40p_csr_trace_fifo.sv
// ---------------------------------------------------------------------------
// cv32e40p_csr_trace_fifo
// Generic synchronous show-ahead FIFO. The head entry is presented
// combinationally from storage; a push is visible at the head no earlier than
// the cycle after it is written (no bypass). Simultaneous push and pop are
// supported, including while full.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i : write request and entry
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : current head entry (undefined when empty)
//   empty_o/full_o: occupancy flags
// Parameters: DEPTH (power of two), entry_t (entry type)
// ---------------------------------------------------------------------------
module cv32e40p_csr_trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [31:0]
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   empty_o,
    output logic   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO only succeeds when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_DEPTH);
    assign head_o  = mem[rd_ptr];

    // Storage needs no reset: the head is only meaningful when not empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_csr_trace_buf.sv
// ---------------------------------------------------------------------------
// cv32e40p_csr_trace_buf
// Captures distinct CSR write events from the core subsystem into a FIFO and
// streams them out over valid/ready. After program exit, capture stops, the
// FIFO drains and done_o is raised.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   csr_access_ex_i, csr_wdata_i : CSR access observation from EX stage
//   exit_valid_i, exit_value_i   : program exit strobe and code
//   trc_valid_o/trc_ready_i      : trace stream handshake
//   trc_wdata_o, trc_ts_o        : head entry data and capture timestamp
//   dropped_o, overflow_o        : saturating drop count, sticky drop flag
//   done_o, exit_code_o          : drained-after-exit flag, latched exit code
// Optional feature macro: CV32E40P_CSR_TRACE_TS_EN
//   defined   : cycle counter runs and each entry stores its timestamp
//   undefined : no counter or timestamp storage, trc_ts_o tied to zero
// ---------------------------------------------------------------------------
module cv32e40p_csr_trace_buf
    import cv32e40p_csr_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             csr_access_ex_i,
    input  logic [31:0]      csr_wdata_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             trc_valid_o,
    input  logic             trc_ready_i,
    output logic [31:0]      trc_wdata_o,
    output logic [CNT_W-1:0] trc_ts_o,
    output logic [CNT_W-1:0] dropped_o,
    output logic             overflow_o,
    output logic             done_o,
    output logic [31:0]      exit_code_o
);

`ifdef CV32E40P_CSR_TRACE_TS_EN
    typedef struct packed {
        logic [31:0]      wdata;
        logic [CNT_W-1:0] ts;
    } entry_t;
`else
    typedef logic [31:0] entry_t;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    trace_state_t state;
    logic         prev_access;
    logic [31:0]  prev_wdata;
    logic         csr_event;
    logic         capture;
    logic         pop;
    logic         drop;
    logic         fifo_full;
    logic         fifo_empty;
    entry_t       push_entry;
    entry_t       head_entry;

    // A held EX stage with unchanged data is one event, not one per cycle.
    assign csr_event = csr_access_ex_i && (!prev_access || (csr_wdata_i != prev_wdata));
    assign capture   = csr_event && (state == ST_RUN);
    assign pop       = !fifo_empty && trc_ready_i;
    assign drop      = capture && fifo_full && !pop;

    assign trc_valid_o = !fifo_empty;
    assign done_o      = (state == ST_DONE);

`ifdef CV32E40P_CSR_TRACE_TS_EN
    logic [CNT_W-1:0] cycle_cnt;

    // Free-running cycle counter used as the capture timestamp.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
        end
    end

    assign push_entry  = '{wdata: csr_wdata_i, ts: cycle_cnt};
    assign trc_wdata_o = fifo_empty ? '0 : head_entry.wdata;
    assign trc_ts_o    = fifo_empty ? '0 : head_entry.ts;
`else
    assign push_entry  = csr_wdata_i;
    assign trc_wdata_o = fifo_empty ? '0 : head_entry;
    assign trc_ts_o    = '0;
`endif

    cv32e40p_csr_trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (capture),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Registered copies of the EX observation for change detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_access <= 1'b0;
            prev_wdata  <= '0;
        end else begin
            prev_access <= csr_access_ex_i;
            prev_wdata  <= csr_wdata_i;
        end
    end

    // Drop accounting: the count saturates, the flag is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dropped_o  <= '0;
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (dropped_o != '1) begin
                dropped_o <= dropped_o + CNT_ONE;
            end
        end
    end

    // Capture state machine: RUN until exit, DRAIN until empty, then DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_RUN;
            exit_code_o <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exit_valid_i) begin
                        exit_code_o <= exit_value_i;
                        state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
